// File: rtl/bip_debug_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : bip_debug_sequencer
//  Purpose  : Run-control sequencer for the BIP core. Decodes single-byte
//             UART commands (0x01 RUN, 0x02 STEP, 0x03 ABORT, 0x04 CPU_RESET),
//             gates the core clock enable, counts executed cycles and, when
//             execution stops, streams a 6-byte status report
//             (PC, ACC, CYC; 16 bits each, MSB first) to the UART transmitter.
//  Optional : `define DEBUG_TIMEOUT_EN adds a run limit (TIMEOUT_CYCLES) and
//             the o_timeout status port.
//  Ports    : i_clock, i_reset       clock, synchronous active-high reset
//             i_rx_data, i_rx_valid  received command byte + valid pulse
//             i_tx_done              transmitter finished current byte
//             o_tx_data, o_tx_start  byte to send + one-cycle start pulse
//             i_halt, i_pc, i_acc    core status (halt decode, PC, ACC)
//             o_cpu_enable           core clock enable
//             o_cpu_reset            one-cycle core reset pulse
//             o_timeout              run ended by timeout (optional)
//  Revision : 1.0 - initial release
// ============================================================================
module bip_debug_sequencer #(
    parameter int NB_ADDR   = 11,
    parameter int NB_DATA   = 16,
    parameter int NB_BYTE   = 8,
    parameter int NB_CYCLES = 16
`ifdef DEBUG_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 16'hFFF0
`endif
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic [NB_BYTE-1:0] i_rx_data,
    input  logic               i_rx_valid,
    input  logic               i_tx_done,
    output logic [NB_BYTE-1:0] o_tx_data,
    output logic               o_tx_start,
    input  logic               i_halt,
    input  logic [NB_ADDR-1:0] i_pc,
    input  logic [NB_DATA-1:0] i_acc,
    output logic               o_cpu_enable,
    output logic               o_cpu_reset
`ifdef DEBUG_TIMEOUT_EN
    ,
    output logic               o_timeout
`endif
);

    localparam logic [NB_BYTE-1:0] c_cmd_run   = NB_BYTE'(8'h01);
    localparam logic [NB_BYTE-1:0] c_cmd_step  = NB_BYTE'(8'h02);
    localparam logic [NB_BYTE-1:0] c_cmd_abort = NB_BYTE'(8'h03);
    localparam logic [NB_BYTE-1:0] c_cmd_creset = NB_BYTE'(8'h04);
    localparam logic [2:0]         c_last_idx  = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CPU_RST = 3'd1,
        S_RUN     = 3'd2,
        S_STEP    = 3'd3,
        S_REPORT  = 3'd4,
        S_TX_WAIT = 3'd5
    } state_t;

    state_t               state_q, state_d;
    logic                 run_after_rst_q, run_after_rst_d;
    logic                 cpu_reset_q;
    logic [NB_CYCLES-1:0] cycles_q, cycles_d;
    logic [NB_CYCLES-1:0] cycles_inc;
    logic [2:0]           idx_q, idx_d;
    logic [NB_BYTE-1:0]   tx_data_q, tx_data_d;
    logic                 tx_start_q, tx_start_d;
    logic [15:0]          pc_snap_q, acc_snap_q, cyc_snap_q;

    logic cmd_run, cmd_step, cmd_abort, cmd_creset;
    logic timeout_hit;

    assign cmd_run    = i_rx_valid && (i_rx_data == c_cmd_run);
    assign cmd_step   = i_rx_valid && (i_rx_data == c_cmd_step);
    assign cmd_abort  = i_rx_valid && (i_rx_data == c_cmd_abort);
    assign cmd_creset = i_rx_valid && (i_rx_data == c_cmd_creset);

    // Saturating increment: the counter sticks at all-ones instead of wrapping.
    assign cycles_inc = (cycles_q == '1) ? cycles_q : cycles_q + NB_CYCLES'(1);

    // Report byte selector: fields zero-extended/truncated to 16 bits, MSB first.
    function automatic logic [7:0] report_byte(input logic [15:0] pc,
                                               input logic [15:0] acc,
                                               input logic [15:0] cyc,
                                               input logic [2:0]  idx);
        logic [7:0] b;
        case (idx)
            3'd0:    b = pc[15:8];
            3'd1:    b = pc[7:0];
            3'd2:    b = acc[15:8];
            3'd3:    b = acc[7:0];
            3'd4:    b = cyc[15:8];
            default: b = cyc[7:0];
        endcase
        return b;
    endfunction

`ifdef DEBUG_TIMEOUT_EN
    logic timeout_q, timeout_d;

    assign timeout_hit = (cycles_q == NB_CYCLES'(TIMEOUT_CYCLES));

    // Set only when the limit alone ends the run; cleared when a new
    // RUN/STEP is accepted.
    always_comb begin
        timeout_d = timeout_q;
        if ((state_q == S_IDLE) && (cmd_run || cmd_step)) begin
            timeout_d = 1'b0;
        end else if ((state_q == S_RUN) && timeout_hit && !i_halt && !cmd_abort) begin
            timeout_d = 1'b1;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= timeout_d;
        end
    end

    assign o_timeout = timeout_q;
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d         = state_q;
        run_after_rst_d = run_after_rst_q;
        cycles_d        = cycles_q;
        idx_d           = idx_q;
        tx_data_d       = tx_data_q;
        tx_start_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cmd_run) begin
                    state_d         = S_CPU_RST;
                    run_after_rst_d = 1'b1;
                end else if (cmd_creset) begin
                    state_d         = S_CPU_RST;
                    run_after_rst_d = 1'b0;
                end else if (cmd_step) begin
                    state_d = S_STEP;
                end
            end

            S_CPU_RST: begin
                cycles_d = '0;
                state_d  = run_after_rst_q ? S_RUN : S_IDLE;
            end

            S_RUN: begin
                // A halted cycle (or reaching the limit) is not counted;
                // an ABORT cycle with the core running is.
                if (!i_halt && !timeout_hit) begin
                    cycles_d = cycles_inc;
                end
                if (i_halt || cmd_abort || timeout_hit) begin
                    state_d = S_REPORT;
                end
            end

            S_STEP: begin
                if (!i_halt) begin
                    cycles_d = cycles_inc;
                end
                state_d = S_REPORT;
            end

            S_REPORT: begin
                // Core is frozen here, so the live inputs equal the snapshot
                // being captured at this same edge.
                idx_d      = 3'd0;
                tx_data_d  = NB_BYTE'(report_byte(16'(i_pc), 16'(i_acc),
                                                  16'(cycles_q), 3'd0));
                tx_start_d = 1'b1;
                state_d    = S_TX_WAIT;
            end

            S_TX_WAIT: begin
                if (i_tx_done) begin
                    if (idx_q == c_last_idx) begin
                        state_d = S_IDLE;
                    end else begin
                        idx_d      = idx_q + 3'd1;
                        tx_data_d  = NB_BYTE'(report_byte(pc_snap_q, acc_snap_q,
                                                          cyc_snap_q, idx_q + 3'd1));
                        tx_start_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q         <= S_IDLE;
            run_after_rst_q <= 1'b0;
            cpu_reset_q     <= 1'b0;
            cycles_q        <= '0;
            idx_q           <= '0;
            tx_data_q       <= '0;
            tx_start_q      <= 1'b0;
            pc_snap_q       <= '0;
            acc_snap_q      <= '0;
            cyc_snap_q      <= '0;
        end else begin
            state_q         <= state_d;
            run_after_rst_q <= run_after_rst_d;
            cpu_reset_q     <= (state_d == S_CPU_RST);
            cycles_q        <= cycles_d;
            idx_q           <= idx_d;
            tx_data_q       <= tx_data_d;
            tx_start_q      <= tx_start_d;
            if (state_q == S_REPORT) begin
                pc_snap_q  <= 16'(i_pc);
                acc_snap_q <= 16'(i_acc);
                cyc_snap_q <= 16'(cycles_q);
            end
        end
    end

    assign o_cpu_enable = (state_q == S_RUN) || (state_q == S_STEP);
    assign o_cpu_reset  = cpu_reset_q;
    assign o_tx_data    = tx_data_q;
    assign o_tx_start   = tx_start_q;

endmodule
`default_nettype wire

// File: tb/tb_bip_debug_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bip_debug_sequencer
//  Purpose  : Directed self-checking bench for bip_debug_sequencer with a
//             small core model (PC advances when enabled and not halted,
//             halts at a programmable PC) and a handshaking UART TX model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bip_debug_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        tx_done;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        halt;
    logic [10:0] pc;
    logic [15:0] acc;
    logic        cpu_en;
    logic        cpu_rst;
`ifdef DEBUG_TIMEOUT_EN
    logic        timeout;
`endif

    always #5 clk = ~clk;

    bip_debug_sequencer #(
        .NB_ADDR   (11),
        .NB_DATA   (16),
        .NB_BYTE   (8),
        .NB_CYCLES (16)
`ifdef DEBUG_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES (10)
`endif
    ) dut (
        .i_clock      (clk),
        .i_reset      (rst),
        .i_rx_data    (rx_data),
        .i_rx_valid   (rx_valid),
        .i_tx_done    (tx_done),
        .o_tx_data    (tx_data),
        .o_tx_start   (tx_start),
        .i_halt       (halt),
        .i_pc         (pc),
        .i_acc        (acc),
        .o_cpu_enable (cpu_en),
        .o_cpu_reset  (cpu_rst)
`ifdef DEBUG_TIMEOUT_EN
        ,
        .o_timeout    (timeout)
`endif
    );

    // Core model
    logic [10:0] pc_m = '0;
    logic        halt_en;
    logic [10:0] halt_at;
    assign pc   = pc_m;
    assign halt = halt_en && (pc_m == halt_at);
    always @(posedge clk) begin
        if (cpu_rst)              pc_m <= '0;
        else if (cpu_en && !halt) pc_m <= pc_m + 11'd1;
    end

    // Event counters sampled on the falling edge
    int en_cnt = 0, rst_cnt = 0, st_cnt = 0;
    always @(negedge clk) begin
        if (cpu_en)   en_cnt  <= en_cnt + 1;
        if (cpu_rst)  rst_cnt <= rst_cnt + 1;
        if (tx_start) st_cnt  <= st_cnt + 1;
    end

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] got [0:5];
    int         e0, r0, s0, fn;

    localparam logic [7:0] RUN = 8'h01, STEP = 8'h02, ABORT = 8'h03;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_cmd(input logic [7:0] c);
        rx_data  = c;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic mark();
        e0 = en_cnt; r0 = rst_cnt; s0 = st_cnt;
    endtask

    task automatic chk_counts(input string tag, input int en_exp, input int rst_exp, input int st_exp);
        repeat (5) tick();
        chk({tag, "_enable_cycles"}, en_cnt - e0, en_exp);
        chk({tag, "_cpu_reset_pulses"}, rst_cnt - r0, rst_exp);
        chk({tag, "_tx_starts"}, st_cnt - s0, st_exp);
    endtask

    task automatic chk_bytes(input string tag, input logic [47:0] exp);
        for (int b = 0; b < 6; b++)
            chk($sformatf("%s_byte%0d", tag, b), got[b], exp[47-8*b -: 8]);
    endtask

    // Serve one report: wait for each start, hold i_tx_done off for d cycles,
    // optionally inject a command byte, optionally reset at byte rst_b.
    task automatic do_report(input int d, input bit inj, input int inj_b,
                             input logic [7:0] inj_c, input int rst_b,
                             output int first_n);
        bit stable_ok, gap_ok;
        int n;
        stable_ok = 1'b1;
        gap_ok    = 1'b1;
        first_n   = -1;
        for (int b = 0; b < 6; b++) begin
            n = 0;
            while (tx_start !== 1'b1 && n < 300) begin
                tick();
                n++;
            end
            if (b == 0) first_n = n;
            if (tx_start !== 1'b1) begin
                chk($sformatf("tx_start_wait_byte%0d", b), tx_start, 1);
                return;
            end
            got[b] = tx_data;
            if (b == rst_b) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                return;
            end
            for (int i = 0; i < d; i++) begin
                tick();
                rx_data  = inj_c;
                rx_valid = inj && (b == inj_b) && (i == 0);
                if (tx_start !== 1'b0) gap_ok = 1'b0;
                if (tx_data !== got[b]) stable_ok = 1'b0;
            end
            rx_valid = 1'b0;
            tx_done  = 1'b1;
            tick();
            tx_done  = 1'b0;
        end
        chk("tx_data_stable", stable_ok, 1);
        chk("no_start_while_busy", gap_ok, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; tx_done = 1'b0;
        halt_en = 1'b0; halt_at = 11'd0; acc = 16'h1234;
        repeat (3) tick();
        chk("reset_cpu_enable", cpu_en, 0);
        chk("reset_cpu_reset", cpu_rst, 0);
        chk("reset_tx_start", tx_start, 0);
        chk("reset_tx_data", tx_data, 0);
`ifdef DEBUG_TIMEOUT_EN
        chk("reset_timeout", timeout, 0);
`endif
        rst = 1'b0;
        tick();

        // RUN, halt after 5 counted cycles
        halt_en = 1'b1; halt_at = 11'd5;
        mark();
        send_cmd(RUN);
        do_report(2, 0, 0, 8'h00, 6, fn);
        chk("run_halt_to_first_start", fn, 8);
        chk_bytes("run1", 48'h0005_1234_0005);
        chk_counts("run1", 6, 1, 6);

        // STEP continues the counter, core advances 5 -> 6
        halt_en = 1'b0;
        mark();
        send_cmd(STEP);
        chk("step_enable", cpu_en, 1);
        do_report(2, 0, 0, 8'h00, 6, fn);
        chk_bytes("step1", 48'h0006_1234_0006);
        chk_counts("step1", 1, 0, 6);

`ifndef DEBUG_TIMEOUT_EN
        // RUN with ABORT in the 100th run cycle; ABORT during TX ignored
        mark();
        send_cmd(RUN);
        chk("abort_run_cpu_reset", cpu_rst, 1);
        chk("abort_run_enable_in_cpu_rst", cpu_en, 0);
        tick();
        chk("abort_run_enable_latency", cpu_en, 1);
        repeat (99) tick();
        send_cmd(ABORT);
        do_report(2, 1, 3, ABORT, 6, fn);
        chk_bytes("abort", 48'h0064_1234_0064);
        chk_counts("abort", 100, 1, 6);
`endif

        // Slow transmitter, RUN injected mid-report
        halt_en = 1'b1; halt_at = 11'd5;
        mark();
        send_cmd(RUN);
        do_report(50, 1, 2, RUN, 6, fn);
        chk_bytes("slow", 48'h0005_1234_0005);
        chk_counts("slow", 6, 1, 6);

        // Unknown byte and ABORT in IDLE are ignored
        mark();
        send_cmd(8'h07);
        send_cmd(ABORT);
        send_cmd(8'hFF);
        chk_counts("idle_ignore", 0, 0, 0);

        // i_reset in the middle of RUN
        halt_en = 1'b0;
        send_cmd(RUN);
        chk("rst_run_cpu_reset", cpu_rst, 1);
        tick();
        chk("rst_run_enable", cpu_en, 1);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_run_enable_after", cpu_en, 0);
        chk("rst_run_tx_data_after", tx_data, 0);
        mark();
        repeat (15) tick();
        chk("rst_run_no_start", st_cnt - s0, 0);
        chk("rst_run_no_enable", en_cnt - e0, 0);

        // i_reset at report byte 3
        halt_en = 1'b1; halt_at = 11'd5;
        send_cmd(RUN);
        do_report(2, 0, 0, 8'h00, 3, fn);
        chk("rst_rep_byte0", got[0], 8'h00);
        chk("rst_rep_byte2", got[2], 8'h12);
        chk("rst_rep_byte3", got[3], 8'h34);
        chk("rst_rep_tx_start", tx_start, 0);
        chk("rst_rep_tx_data", tx_data, 0);
        chk("rst_rep_cpu_enable", cpu_en, 0);
        mark();
        repeat (100) tick();
        chk("rst_rep_no_start", st_cnt - s0, 0);

        // STEP after reset: counter restarted from 0
        halt_en = 1'b0;
        mark();
        send_cmd(STEP);
        do_report(2, 0, 0, 8'h00, 6, fn);
        chk_bytes("step2", 48'h0006_1234_0001);
        chk_counts("step2", 1, 0, 6);

        // Halt and ABORT in the same cycle: halt rule for the counter
        halt_en = 1'b1; halt_at = 11'd3;
        send_cmd(RUN);
        repeat (4) tick();
        send_cmd(ABORT);
        do_report(2, 0, 0, 8'h00, 6, fn);
        chk_bytes("halt_abort", 48'h0003_1234_0003);

`ifdef DEBUG_TIMEOUT_EN
        // Run limit of 10 with the core never halting
        halt_en = 1'b0;
        send_cmd(RUN);
        do_report(2, 0, 0, 8'h00, 6, fn);
        chk_bytes("timeout", 48'h000B_1234_000A);
        repeat (5) tick();
        chk("timeout_flag_set", timeout, 1);
        halt_en = 1'b1; halt_at = 11'd5;
        send_cmd(RUN);
        chk("timeout_flag_cleared", timeout, 0);
        do_report(2, 0, 0, 8'h00, 6, fn);
        chk_bytes("after_timeout", 48'h0005_1234_0005);
        chk("timeout_flag_halt_end", timeout, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
